// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the controller-to-datapath control word.
package div_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2
    } state_t;

    // One strobe per datapath action; the controller asserts a subset each cycle.
    typedef struct packed {
        logic ld_q;     // Q <- dividend
        logic ld_b;     // B <- divisor, div_by_zero <- (divisor == 0)
        logic init_a;   // A <- 0
        logic shift;    // perform one shift/trial step on A and Q
        logic ld_a;     // trial succeeded: A takes T instead of S
        logic set_q0;   // quotient bit shifted into Q[0]
        logic cnt_en;   // step counter increments
        logic cnt_clr;  // step counter clears
        logic done;     // idle / result valid
    } ctrl_word_t;

endpackage

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the sequencer and the divider.
interface seq_divider_if import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

    logic             go;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output go, dividend, divisor,
        input  quotient, remainder, done, busy, div_by_zero
    );

    modport slave (
        input  go, dividend, divisor,
        output quotient, remainder, done, busy, div_by_zero
    );

endinterface

// File: rtl/seq_divider_ctrl.sv
// Divider controller: IDLE/LOAD/ITER sequencing plus the step counter.
// Emits a control word each cycle from the state, go and the trial sign.
//
//   state | meaning
//   IDLE  | result valid (done=1); wait for go
//   LOAD  | capture operands every cycle while go=1; leave when go falls
//   ITER  | one quotient bit per cycle, WIDTH cycles, go ignored
module seq_divider_ctrl import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clck,
    input  logic       rst,
    input  logic       go,
    input  logic       t_sign,
    output ctrl_word_t cw
);

    localparam int              CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           ps, ns;
    logic [CNT_W-1:0] count;

    // State register and step counter.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            ps    <= IDLE;
            count <= '0;
        end else begin
            ps <= ns;
            if (cw.cnt_clr)
                count <= '0;
            else if (cw.cnt_en)
                count <= count + 1'b1;
        end
    end

    // Next-state and control word decode.
    always_comb begin
        ns = IDLE;
        cw = '0;
        case (ps)
            IDLE: begin
                cw.done = 1'b1;
                ns      = go ? LOAD : IDLE;
            end
            LOAD: begin
                cw.ld_q    = 1'b1;
                cw.ld_b    = 1'b1;
                cw.init_a  = 1'b1;
                cw.cnt_clr = 1'b1;
                ns         = go ? LOAD : ITER;
            end
            ITER: begin
                cw.shift  = 1'b1;
                cw.cnt_en = 1'b1;
                cw.ld_a   = ~t_sign;
                cw.set_q0 = ~t_sign;
                ns        = (count == LAST) ? IDLE : ITER;
            end
            default: ns = IDLE;
        endcase
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Datapath (A, Q, B and the trial subtractor) lives here; sequencing is in
// seq_divider_ctrl.
module seq_divider import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          clck,
    input  logic          rst,
    seq_divider_if.slave  bus
);

    ctrl_word_t     cw;
    logic [WIDTH:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic           dbz;
    logic [WIDTH:0] s;
    logic [WIDTH:0] t;

    // Shifted partial remainder and trial subtraction; T[WIDTH] set means S < B.
    assign s = {a[WIDTH-1:0], q[WIDTH-1]};
    assign t = s - {1'b0, b};

    seq_divider_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clck   (clck),
        .rst    (rst),
        .go     (bus.go),
        .t_sign (t[WIDTH]),
        .cw     (cw)
    );

    // Datapath registers: load on capture, shift/restore during iteration.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            a   <= '0;
            q   <= '0;
            b   <= '0;
            dbz <= 1'b0;
        end else begin
            if (cw.init_a)
                a <= '0;
            else if (cw.shift)
                a <= cw.ld_a ? t : s;

            if (cw.ld_q)
                q <= bus.dividend;
            else if (cw.shift)
                q <= {q[WIDTH-2:0], cw.set_q0};

            if (cw.ld_b) begin
                b   <= bus.divisor;
                dbz <= (bus.divisor == '0);
            end
        end
    end

    assign bus.quotient    = q;
    assign bus.remainder   = a[WIDTH-1:0];
    assign bus.done        = cw.done;
    // The counter is cleared only in LOAD and advanced only in ITER, so
    // together those strobes mark exactly the busy states.
    assign bus.busy        = cw.cnt_clr | cw.cnt_en;
    assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes the arithmetic
// expectation, a negedge monitor pops and compares when an operation ends.
module tb_seq_divider;
    import div_pkg::*;

    localparam int W = 8;

    logic clck = 1'b0;
    logic rst  = 1'b0;

    seq_divider_if #(.WIDTH(W)) bus();

    seq_divider #(.WIDTH(W)) dut (
        .clck (clck),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 clck = ~clck;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic; a zero divisor yields all-ones quotient and the dividend back.
    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t x;
        x.dd = dd;
        x.dv = dv;
        if (dv == 0) begin
            x.q   = '1;
            x.r   = dd;
            x.dbz = 1'b1;
        end else begin
            x.q   = W'(int'(dd) / int'(dv));
            x.r   = W'(int'(dd) % int'(dv));
            x.dbz = 1'b0;
        end
        return x;
    endfunction

    // Monitor: an operation completes when busy falls outside reset.
    always @(negedge clck) begin
        if (rst && busy_prev && !bus.busy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got q=%0d r=%0d required none queued",
                         bus.quotient, bus.remainder);
            end else begin
                e = sb.pop_front();
                check($sformatf("quotient %0d/%0d", e.dd, e.dv), 32'(bus.quotient), 32'(e.q));
                check($sformatf("remainder %0d/%0d", e.dd, e.dv), 32'(bus.remainder), 32'(e.r));
                check($sformatf("div_by_zero %0d/%0d", e.dd, e.dv), 32'(bus.div_by_zero), 32'(e.dbz));
                check("done_with_result", 32'(bus.done), 32'd1);
                if (e.dv != 0)
                    check($sformatf("invariant %0d/%0d", e.dd, e.dv),
                          32'((int'(bus.quotient) * int'(e.dv) + int'(bus.remainder) == int'(e.dd))
                              && (bus.remainder < e.dv)), 32'd1);
            end
        end
        busy_prev = bus.busy;
    end

    // Run one operation: go high for n_go cycles with (dd0,dv0), then go falls
    // with (dd1,dv1) presented on the final LOAD cycle; wait for done.
    task automatic issue(input logic [W-1:0] dd0, input logic [W-1:0] dv0,
                         input logic [W-1:0] dd1, input logic [W-1:0] dv1,
                         input int n_go, input bit toggle);
        int bcnt;
        int edges;
        bcnt = 0;
        edges = 0;
        bus.go       = 1'b1;
        bus.dividend = dd0;
        bus.divisor  = dv0;
        repeat (n_go) begin
            @(posedge clck); #1;
            if (bus.busy) bcnt++;
        end
        bus.go       = 1'b0;
        bus.dividend = dd1;
        bus.divisor  = dv1;
        sb.push_back(model(dd1, dv1));
        while (edges < 3 * W) begin
            @(posedge clck); #1;
            edges++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
            if (toggle) bus.go = 1'($urandom_range(0, 1));
        end
        bus.go = 1'b0;
        check("done_within_budget", 32'(bus.done), 32'd1);
        check("latency_edges", 32'(edges), 32'(W + 1));
        check("busy_cycles", 32'(bcnt), 32'(n_go + W));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] dd, dv, dd0, dv0;
        bus.go       = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("rst_done", 32'(bus.done), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clck); #1;
        rst = 1'b1;
        @(posedge clck); #1;

        issue(8'd100, 8'd7,  8'd100, 8'd7,  1, 1'b0);
        issue(8'd255, 8'd1,  8'd255, 8'd1,  1, 1'b0);
        issue(8'd5,   8'd9,  8'd5,   8'd9,  1, 1'b0);
        issue(8'd200, 8'd0,  8'd200, 8'd0,  1, 1'b0);
        issue(8'd9,   8'd3,  8'd9,   8'd3,  1, 1'b0);
        issue(8'd50,  8'd5,  8'd60,  8'd7,  4, 1'b0);
        issue(8'd100, 8'd7,  8'd100, 8'd7,  1, 1'b1);

        // Abort 100/7 after three iterations.
        bus.go       = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clck); #1;
        bus.go = 1'b0;
        repeat (4) @(posedge clck);
        #1;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_quotient", 32'(bus.quotient), 32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        @(posedge clck); #1;
        @(posedge clck); #1;
        rst = 1'b1;
        @(posedge clck); #1;
        issue(8'd100, 8'd7, 8'd100, 8'd7, 1, 1'b0);

        // Random back-to-back operations, each started in the first done cycle.
        for (int i = 0; i < 1000; i++) begin
            dd0 = W'($urandom_range(0, 255));
            dv0 = W'($urandom_range(0, 255));
            dd  = W'($urandom_range(0, 255));
            dv  = W'($urandom_range(1, 255));
            issue(dd0, dv0, dd, dv, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clck);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
